// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED mode/enable front end: debounce FSM encoding and the
// symbolic pattern-mode values the generator understands.
package led_ctrl_pkg;

    // Debounce FSM states, one FSM per button.
    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StPressWait   = 2'd1,
        StPressed     = 2'd2,
        StReleaseWait = 2'd3
    } deb_state_e;

    // Pattern modes as decoded by the generator.
    localparam logic [1:0] LED_MODE_RUN   = 2'd0;
    localparam logic [1:0] LED_MODE_COUNT = 2'd1;
    localparam logic [1:0] LED_MODE_ALT   = 2'd2;
    localparam logic [1:0] LED_MODE_SCAN  = 2'd3;

endpackage

// File: rtl/button_debouncer.sv
// Single push-button conditioner: 2-FF synchronizer, debounce FSM with a stability
// counter, and a registered one-cycle pulse for every accepted press (never on release).
module button_debouncer
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    output logic press_pulse_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            btn_s;
    deb_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;
    logic            cnt_max;

    assign btn_s   = sync_q[1];
    assign cnt_max = (cnt_q == CntMax);

    // Bring the asynchronous raw button into the clock domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_raw_i};
        end
    end

    // Debounce state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a level is accepted only after the counter runs out while it stays stable.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (btn_s) state_d = StPressWait;
            end
            StPressWait: begin
                if (!btn_s)       state_d = StIdle;
                else if (cnt_max) state_d = StPressed;
            end
            StPressed: begin
                if (!btn_s) state_d = StReleaseWait;
            end
            StReleaseWait: begin
                // Release bounce goes straight back to pressed without a new event.
                if (btn_s)        state_d = StPressed;
                else if (cnt_max) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Counter and press-pulse next values.
    always_comb begin
        cnt_d   = cnt_q;
        press_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (btn_s) cnt_d = '0;
            end
            StPressWait: begin
                if (btn_s) begin
                    if (cnt_max) press_d = 1'b1;
                    else         cnt_d   = cnt_q + 1'b1;
                end
            end
            StPressed: begin
                if (!btn_s) cnt_d = '0;
            end
            StReleaseWait: begin
                if (!btn_s && !cnt_max) cnt_d = cnt_q + 1'b1;
            end
            default: cnt_d = '0;
        endcase
    end

    // Counter and registered press pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_pulse_o = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Button front end for the LED pattern generator: one debouncer per button, a wrapping
// mode register with a change strobe, and a toggling enable.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned NUM_MODES       = 4,
    parameter int unsigned MODE_W          = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              btn_mode_raw,
    input  logic              btn_en_raw,
    output logic [MODE_W-1:0] mode,
    output logic              enable,
    output logic              mode_changed
);

    localparam logic [MODE_W-1:0] ModeLast  = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] ModeReset = MODE_W'(LED_MODE_RUN);

    logic              mode_press;
    logic              en_press;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              enable_q, enable_d;
    logic              changed_q, changed_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_mode (
        .clk_i        (clk),
        .rst_ni       (reset_n),
        .btn_raw_i    (btn_mode_raw),
        .press_pulse_o(mode_press)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_en (
        .clk_i        (clk),
        .rst_ni       (reset_n),
        .btn_raw_i    (btn_en_raw),
        .press_pulse_o(en_press)
    );

    // Apply press events; mode and enable are independent and may update together.
    always_comb begin
        mode_d    = mode_q;
        enable_d  = enable_q;
        changed_d = mode_press;
        if (mode_press) mode_d = (mode_q == ModeLast) ? '0 : mode_q + 1'b1;
        if (en_press)   enable_d = ~enable_q;
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= ModeReset;
            enable_q  <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            enable_q  <= enable_d;
            changed_q <= changed_d;
        end
    end

    assign mode         = mode_q;
    assign enable       = enable_q;
    assign mode_changed = changed_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl with a short debounce window. The reference model treats each
// button as an accepted level that flips after DEB+1 consecutive opposite synchronized
// samples, emitting an event on each flip to "pressed"; outputs react one edge later.
module tb_led_mode_ctrl;

    localparam int DEB   = 8;
    localparam int NMODE = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_mode_raw = 1'b0;
    logic       btn_en_raw = 1'b0;
    logic [1:0] mode;
    logic       enable;
    logic       mode_changed;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_mode = 0;
    bit m_en = 1'b0;
    bit m_chg = 1'b0;
    bit h1 [2];
    bit h2 [2];
    bit lvl [2];
    int run [2];
    bit evt [2];

    led_mode_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .NUM_MODES      (NMODE),
        .MODE_W         (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_mode_raw(btn_mode_raw),
        .btn_en_raw  (btn_en_raw),
        .mode        (mode),
        .enable      (enable),
        .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_en   = 1'b0;
        m_chg  = 1'b0;
        for (int b = 0; b < 2; b++) begin
            h1[b] = 1'b0; h2[b] = 1'b0; lvl[b] = 1'b0; run[b] = 0; evt[b] = 1'b0;
        end
    endtask

    // One clock edge of the model; raw values are those present at the edge.
    task automatic model_edge(input bit rm, input bit re);
        bit raw [2];
        bit s;
        raw[0] = rm;
        raw[1] = re;
        m_chg = evt[0];
        if (evt[0]) m_mode = (m_mode + 1) % NMODE;
        if (evt[1]) m_en = !m_en;
        for (int b = 0; b < 2; b++) begin
            s = h2[b];  // raw level from two edges ago
            evt[b] = 1'b0;
            if (s != lvl[b]) begin
                run[b]++;
                if (run[b] == DEB + 1) begin
                    lvl[b] = s;
                    run[b] = 0;
                    evt[b] = s;
                end
            end else begin
                run[b] = 0;
            end
            h2[b] = h1[b];
            h1[b] = raw[b];
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_mode"}, {6'd0, mode}, 8'(m_mode));
        chk({tag, "_en"}, {7'd0, enable}, {7'd0, m_en});
        chk({tag, "_chg"}, {7'd0, mode_changed}, {7'd0, m_chg});
    endtask

    // Drive inputs, take one edge, update the model, then compare mid-cycle.
    task automatic step(input bit rm, input bit re, input string tag);
        btn_mode_raw = rm;
        btn_en_raw   = re;
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_edge(rm, re);
        #1;
        check_outputs(tag);
    endtask

    task automatic hold(input bit rm, input bit re, input int n, input string tag);
        for (int i = 0; i < n; i++) step(rm, re, tag);
    endtask

    initial begin
        model_reset();
        #1;
        chk("reset_mode", {6'd0, mode}, 8'd0);
        chk("reset_en", {7'd0, enable}, 8'd0);
        chk("reset_chg", {7'd0, mode_changed}, 8'd0);
        hold(1'b0, 1'b0, 3, "in_reset");
        reset_n = 1'b1;

        // 1: idle
        hold(1'b0, 1'b0, 50, "t1_idle");

        // 2: long hold gives exactly one event at edge DEB+4
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, 1'b0, "t2_hold");
            if (i == DEB + 3) chk("t2_pre", {5'd0, mode, mode_changed}, 8'b000);
            if (i == DEB + 4) chk("t2_edge", {5'd0, mode, mode_changed}, 8'b011);
            if (i == DEB + 5) chk("t2_post", {5'd0, mode, mode_changed}, 8'b010);
        end
        hold(1'b0, 1'b0, 30, "t2_release");

        // 3: short glitches are ignored
        for (int r = 0; r < 3; r++) begin
            hold(1'b1, 1'b0, 5, "t3_glitch");
            hold(1'b0, 1'b0, 10, "t3_low");
        end
        chk("t3_mode", {6'd0, mode}, 8'd1);

        // 4: four clean presses wrap the mode back around
        for (int r = 0; r < 4; r++) begin
            hold(1'b1, 1'b0, 30, "t4_press");
            hold(1'b0, 1'b0, 30, "t4_low");
        end
        chk("t4_mode", {6'd0, mode}, 8'd1);

        // 5: simultaneous presses, then a second enable press
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, 1'b1, "t5_both");
            if (i == DEB + 4) chk("t5_edge", {5'd0, mode, enable}, 8'b101);
        end
        hold(1'b0, 1'b0, 30, "t5_low");
        hold(1'b0, 1'b1, 30, "t5_en2");
        hold(1'b0, 1'b0, 30, "t5_low2");
        chk("t5_en_off", {7'd0, enable}, 8'd0);

        // 6: release bounce, then reset mid-debounce with the button held
        hold(1'b1, 1'b0, 30, "t6_press");
        hold(1'b0, 1'b0, 3, "t6_bounce_lo");
        hold(1'b1, 1'b0, 2, "t6_bounce_hi");
        hold(1'b0, 1'b0, 20, "t6_release");
        chk("t6_mode", {6'd0, mode}, 8'd3);
        hold(1'b1, 1'b0, 7, "t6_partial");
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_mode", {6'd0, mode}, 8'd0);
        chk("t6_rst_en", {7'd0, enable}, 8'd0);
        chk("t6_rst_chg", {7'd0, mode_changed}, 8'd0);
        hold(1'b1, 1'b0, 3, "t6_in_reset");
        reset_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, "t6_held");
            if (i == DEB + 4) chk("t6_edge", {5'd0, mode, mode_changed}, 8'b011);
        end
        hold(1'b0, 1'b0, 30, "t6_low");

        // Randomized hold lengths on both buttons, including sub-window glitches
        for (int r = 0; r < 300; r++) begin
            bit rm;
            bit re;
            int n;
            rm = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            n  = int'($urandom_range(1, 2 * DEB + 4));
            hold(rm, re, n, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
